// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/subtract with a valid/ready handshake.
// Rank 0 registers the effective operands (A, B' = Sub ? ~B : B, c0).
// Ranks 1..STAGES each ripple one SEG-bit segment using the carry from the
// previous rank, so latency is STAGES cycles from acceptance to out_valid.
// A single global advance signal stalls every rank together.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand beat handshake
//   A, B, Cin, Sub        operands, carry-in (add only), subtract select
//   out_valid / out_ready result beat handshake
//   Sum                   WIDTH+1-bit result, Sum[WIDTH] = carry-out
//   Ovf                   signed overflow of the WIDTH-bit result
module pipelined_rca #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Sum,
  output logic             Ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;
  localparam int unsigned NR  = STAGES + 1;

  logic [NR-1:0]    valid_q, valid_d;
  logic [NR-1:0]    carry_q, carry_d;
  logic [WIDTH-1:0] a_q [NR];
  logic [WIDTH-1:0] a_d [NR];
  logic [WIDTH-1:0] b_q [NR];
  logic [WIDTH-1:0] b_d [NR];
  logic [WIDTH-1:0] s_q [NR];
  logic [WIDTH-1:0] s_d [NR];
  logic             ovf_q, ovf_d;
  logic             live_q;
  logic             adv_c;

  // Next-state for all ranks; everything holds unless the pipe advances.
  always_comb begin : next_state
    logic [WIDTH-1:0] pa, pb, ps;
    logic             cy;
    int unsigned      idx;
    adv_c   = out_ready | ~valid_q[NR-1];
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    pa      = '0;
    pb      = '0;
    ps      = '0;
    cy      = 1'b0;
    idx     = 0;
    if (adv_c) begin
      // Operand rank; live_q keeps the block closed until one edge after reset.
      valid_d[0] = in_valid & live_q;
      if (in_valid & live_q) begin
        a_d[0]     = A;
        b_d[0]     = Sub ? ~B : B;
        s_d[0]     = '0;
        carry_d[0] = Sub | Cin;
      end
      // Rank k ripples segment k-1 through one full adder per bit.
      for (int unsigned k = 1; k < NR; k++) begin
        pa = a_q[k-1];
        pb = b_q[k-1];
        ps = s_q[k-1];
        cy = carry_q[k-1];
        for (int unsigned i = 0; i < SEG; i++) begin
          idx     = (k - 1) * SEG + i;
          ps[idx] = pa[idx] ^ pb[idx] ^ cy;
          cy      = (pa[idx] & pb[idx]) | (cy & (pa[idx] ^ pb[idx]));
        end
        valid_d[k] = valid_q[k-1];
        // Data only moves with a valid beat, so bubbles leave Sum untouched.
        if (valid_q[k-1]) begin
          a_d[k]     = pa;
          b_d[k]     = pb;
          s_d[k]     = ps;
          carry_d[k] = cy;
        end
      end
      // Overflow needs the finished sign bit, so it is formed in the last rank.
      if (valid_q[NR-2]) begin
        ovf_d = (a_q[NR-2][WIDTH-1] == b_q[NR-2][WIDTH-1]) &&
                (s_d[NR-1][WIDTH-1] != a_q[NR-2][WIDTH-1]);
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
      for (int unsigned k = 0; k < NR; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      live_q  <= 1'b1;
      for (int unsigned k = 0; k < NR; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign in_ready  = adv_c & live_q;
  assign out_valid = valid_q[NR-1];
  assign Sum       = {carry_q[NR-1], s_q[NR-1]};
  assign Ovf       = ovf_q;

endmodule
